// File: rtl/increment_term_generator.sv
// Generates per-element comparator terms L_kn = 2k + 1 + B_n for a linear array:
// fill outward from ORIGIN once per scanline, then step every term by K_STEP per point.
// Optional macro INCR_TERM_SATURATE_EN: saturating arithmetic with sticky ovf flag.
module increment_term_generator #(
    parameter int NUM_ELEMENTS = 64,
    parameter int ORIGIN       = 32,
    parameter int DW_ACC       = 25,
    parameter int DW_FRAC      = 8,
    parameter int TRUNC        = 4,
    parameter int K_STEP       = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [DW_ACC-2:0]                       r0_term,
    input  logic [DW_ACC-1:0]                       delta,
    input  logic                                    abort,
    output logic                                    out_valid,
    input  logic                                    out_ack,
    input  logic                                    final_point,
    output logic [NUM_ELEMENTS*(DW_ACC-TRUNC)-1:0]  terms,
    output logic                                    busy,
    output logic                                    ovf,
    output logic [2:0]                              state_dbg
);
    localparam int DW_OUT = DW_ACC - TRUNC;
    localparam int DMAX   = (ORIGIN > NUM_ELEMENTS-1-ORIGIN) ? ORIGIN : NUM_ELEMENTS-1-ORIGIN;
    localparam int DW_D   = $clog2(NUM_ELEMENTS) + 1;
    localparam logic [DW_ACC-1:0] ONE   = DW_ACC'(1 << DW_FRAC);
    localparam logic [DW_ACC-1:0] K_INC = DW_ACC'(K_STEP << DW_FRAC);

    // Handshakes: cfg transfers on an edge where cfg_valid && cfg_ready; terms transfer on an
    // edge where out_valid && out_ack. out_valid rises one cycle after VALID entry, drops on ack.
    typedef enum logic [2:0] {IDLE, INIT, FILL, VALID, STEP} state_t;

    state_t              state;
    logic [DW_D-1:0]     d;
    logic [DW_ACC-2:0]   r0_q;
    logic [DW_ACC-1:0]   delta_q;
    logic                ovf_q;
    logic [DW_ACC-1:0]   acc     [NUM_ELEMENTS];
    logic [DW_ACC-1:0]   acc_nxt [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] sat_ev;

    // Returns {saturation_event, result} for a +/- b in DW_ACC two's complement.
    function automatic logic [DW_ACC:0] arith(input logic [DW_ACC-1:0] a,
                                              input logic [DW_ACC-1:0] b,
                                              input logic              sub);
`ifdef INCR_TERM_SATURATE_EN
        logic [DW_ACC:0] w;
        w = sub ? ({a[DW_ACC-1], a} - {b[DW_ACC-1], b}) : ({a[DW_ACC-1], a} + {b[DW_ACC-1], b});
        if (w[DW_ACC] != w[DW_ACC-1])
            return w[DW_ACC] ? {1'b1, 1'b1, {(DW_ACC-1){1'b0}}} : {1'b1, 1'b0, {(DW_ACC-1){1'b1}}};
        return {1'b0, w[DW_ACC-1:0]};
`else
        logic [DW_ACC-1:0] w;
        w = sub ? (a - b) : (a + b);
        return {1'b0, w};
`endif
    endfunction

    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_elem
        logic [DW_ACC:0] res;
        if (i == ORIGIN) begin : g_org
            always_comb begin
                res = {1'b0, acc[i]};
                if (state == STEP)      res = arith(acc[i], K_INC, 1'b0);
                else if (state == INIT) res = arith(ONE, {1'b0, r0_q}, 1'b0);
            end
        end else if (i > ORIGIN) begin : g_up
            always_comb begin
                res = {1'b0, acc[i]};
                if (state == STEP) res = arith(acc[i], K_INC, 1'b0);
                else if (state == FILL && d == DW_D'(i - ORIGIN)) res = arith(acc[i-1], delta_q, 1'b1);
            end
        end else begin : g_dn
            always_comb begin
                res = {1'b0, acc[i]};
                if (state == STEP) res = arith(acc[i], K_INC, 1'b0);
                else if (state == FILL && d == DW_D'(ORIGIN - i)) res = arith(acc[i+1], delta_q, 1'b0);
            end
        end
        assign acc_nxt[i] = res[DW_ACC-1:0];
        assign sat_ev[i]  = res[DW_ACC];
        assign terms[i*DW_OUT +: DW_OUT] = acc[i][DW_ACC-1:TRUNC];
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state     <= IDLE;
            d         <= '0;
            r0_q      <= '0;
            delta_q   <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_ELEMENTS; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        r0_q      <= r0_term;
                        delta_q   <= delta;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) acc[i] <= acc_nxt[i];
                    ovf_q <= ovf_q | (|sat_ev);
                    d     <= DW_D'(1);
                    state <= FILL;
                end
                FILL: begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) acc[i] <= acc_nxt[i];
                    ovf_q <= ovf_q | (|sat_ev);
                    if (d == DW_D'(DMAX)) state <= VALID;
                    else                  d     <= d + DW_D'(1);
                end
                VALID: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ack) begin
                        out_valid <= 1'b0;
                        if (final_point) begin
                            for (int i = 0; i < NUM_ELEMENTS; i++) acc[i] <= '0;
                            ovf_q     <= 1'b0;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) acc[i] <= acc_nxt[i];
                    ovf_q <= ovf_q | (|sat_ev);
                    state <= VALID;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ovf       = ovf_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_increment_term_generator.sv
// Directed bench: default 64-element instance plus an 8-element ORIGIN=0 instance.
module tb_increment_term_generator;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0, cfg_ready;
    logic [23:0]   r0_term = '0;
    logic [24:0]   delta = '0;
    logic          abort = 1'b0, out_valid, out_ack = 1'b0, final_point = 1'b0;
    logic [1343:0] terms;
    logic          busy, ovf;
    logic [2:0]    state_dbg;

    logic          cfg_valid_s = 1'b0, cfg_ready_s;
    logic [23:0]   r0_s = '0;
    logic [24:0]   delta_s = '0;
    logic          abort_s = 1'b0, out_valid_s, out_ack_s = 1'b0, final_s = 1'b0;
    logic [167:0]  terms_s;
    logic          busy_s, ovf_s;
    logic [2:0]    state_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    increment_term_generator u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .r0_term(r0_term), .delta(delta), .abort(abort), .out_valid(out_valid),
        .out_ack(out_ack), .final_point(final_point), .terms(terms), .busy(busy),
        .ovf(ovf), .state_dbg(state_dbg)
    );

    increment_term_generator #(.NUM_ELEMENTS(8), .ORIGIN(0)) u_small (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid_s), .cfg_ready(cfg_ready_s),
        .r0_term(r0_s), .delta(delta_s), .abort(abort_s), .out_valid(out_valid_s),
        .out_ack(out_ack_s), .final_point(final_s), .terms(terms_s), .busy(busy_s),
        .ovf(ovf_s), .state_dbg(state_s)
    );

    typedef struct {
        string       name;
        int          elem;
        logic [20:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] term(input int e);
        return terms[e*21 +: 21];
    endfunction

    task automatic start_cfg(input logic [23:0] r, input logic [24:0] dl);
        r0_term   = r;
        delta     = dl;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_ack(input logic fp);
        out_ack     = 1'b1;
        final_point = fp;
        tick();
        out_ack     = 1'b0;
        final_point = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_terms_zero"}, 64'(|terms), 64'd0);
    endtask

    initial begin
        int  cyc;
        longint v;
        logic [24:0] acc_exp;
        logic ovf_exp;

        vecs[0] = '{"t1_elem32", 32, 21'h000110};
        vecs[1] = '{"t1_elem33", 33, 21'h0000F8};
        vecs[2] = '{"t1_elem31", 31, 21'h000128};
        vecs[3] = '{"t1_elem0",   0, 21'h000410};
        vecs[4] = '{"t1_elem63", 63, 21'h1FFE28};

        tick(); tick();
        rst = 1'b0;
        check_cleared("reset");
        check("reset_ovf", 64'(ovf), 64'd0);

        // Nominal scanline fill
        start_cfg(24'h001000, 25'h0000180);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_cfg_ready", 64'(cfg_ready), 64'd0);
        wait_valid(cyc);
        check("fill_latency", 64'(cyc), 64'd34);
        for (int k = 0; k < 5; k++) check(vecs[k].name, 64'(term(vecs[k].elem)), 64'(vecs[k].exp));

        // Stepping
        do_ack(1'b0);
        check("ack_drop", 64'(out_valid), 64'd0);
        wait_valid(cyc);
        check("step_latency", 64'(cyc), 64'd2);
        check("step1_elem32", 64'(term(32)), 64'h130);
        check("step1_elem63", 64'(term(63)), 64'h1FFE48);
        do_ack(1'b0); wait_valid(cyc);
        do_ack(1'b0); wait_valid(cyc);
        check("step3_elem32", 64'(term(32)), 64'h170);
        check("step3_elem0", 64'(term(0)), 64'h470);

        // Final point returns to IDLE; new config accepted immediately
        do_ack(1'b1);
        check_cleared("final");
        start_cfg(24'h001000, 25'h0000180);
        check("reaccept_busy", 64'(busy), 64'd1);

        // cfg_valid while filling must not disturb the scanline
        r0_term = 24'h000000; delta = 25'h0000007; cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        cfg_valid = 1'b0;
        wait_valid(cyc);
        check("cfg_ignored_latency", 64'(cyc + 4), 64'd34);
        check("cfg_ignored_elem32", 64'(term(32)), 64'h110);
        check("cfg_ignored_elem0", 64'(term(0)), 64'h410);

        // Reset while VALID
        rst = 1'b1; tick(); rst = 1'b0;
        check_cleared("rst_valid");

        // Abort in FILL at d=10
        start_cfg(24'h001000, 25'h0000180);
        for (int k = 0; k < 10; k++) tick();
        check("fill_busy", 64'(busy), 64'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        check_cleared("abort_fill");

        // Abort wins over a simultaneous ack
        start_cfg(24'h001000, 25'h0000180);
        wait_valid(cyc);
        abort = 1'b1; out_ack = 1'b1;
        tick();
        abort = 1'b0; out_ack = 1'b0;
        tick(); tick();
        check_cleared("abort_vs_ack");

        // Asymmetric 8-element instance, ORIGIN=0
        r0_s = 24'h0; delta_s = 25'h1FFFF00; cfg_valid_s = 1'b1;
        tick();
        cfg_valid_s = 1'b0;
        cyc = 0;
        while (!out_valid_s && cyc < 100) begin
            tick();
            cyc++;
        end
        check("small_latency", 64'(cyc), 64'd9);
        check("small_elem0", 64'(terms_s[0*21 +: 21]), 64'h010);
        check("small_elem3", 64'(terms_s[3*21 +: 21]), 64'h040);
        check("small_elem7", 64'(terms_s[7*21 +: 21]), 64'h080);
        check("small_ovf", 64'(ovf_s), 64'd0);

        // Near-full-scale r0: saturate or wrap depending on the build
        start_cfg(24'hFFF000, 25'h0);
        wait_valid(cyc);
        check("big_latency", 64'(cyc), 64'd34);
        check("big_elem32", 64'(term(32)), 64'h0FFF10);
        for (int k = 1; k <= 9; k++) begin
            do_ack(1'b0);
            wait_valid(cyc);
            v = 64'hFFF100 + 64'(512 * k);
`ifdef INCR_TERM_SATURATE_EN
            if (v > 64'hFFFFFF) v = 64'hFFFFFF;
            ovf_exp = (k >= 8);
`else
            ovf_exp = 1'b0;
`endif
            acc_exp = v[24:0];
            check($sformatf("big_step%0d_elem32", k), 64'(term(32)), 64'(acc_exp[24:4]));
            check($sformatf("big_step%0d_ovf", k), 64'(ovf), 64'(ovf_exp));
        end
        check("big_elem0", 64'(term(0)), 64'(acc_exp[24:4]));
        do_ack(1'b1);
        check("big_final_ovf", 64'(ovf), 64'd0);
        check_cleared("big_final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
